dram_capture_writer: RTL

DRAM_CAPTURE_WRITER -- requirements
Module: dram_capture_writer

---
 rtl/dram_capture_writer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dram_capture_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dram_capture_writer: buffers a burst of ADC samples and streams them to     |
// | SDRAM as consecutive Avalon-MM single-word writes.  Rev 1.0                 |
// +-----------------------------------------------------------------------------+
module dram_capture_writer #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              M100CLK,
  input  logic              lock,
  input  logic              arm,
  input  logic [ADDR_W-1:0] record_len,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_write,
  output logic [1:0]        avm_byteenable,
  output logic              avm_chipselect,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] wr_count
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wptr;
  logic [c_PTR_W-1:0]  r_rptr;
  logic [c_PTR_W:0]    r_count;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W-1:0]   r_seen;
  logic [ADDR_W-1:0]   r_avm_address;
  logic [DATA_W-1:0]   r_avm_writedata;
  logic                r_avm_write;
  logic                r_busy;
  logic                r_done;
  logic                r_overflow;
  logic [ADDR_W-1:0]   r_wr_count;

  logic                w_arm_ok;
  logic                w_commit;
  logic                w_take;
  logic                w_push;
  logic                w_drop;
  logic [c_PTR_W-1:0]  w_rptr_next;
  logic [c_PTR_W:0]    w_count_after_pop;
  logic                w_wr_next;

  assign w_arm_ok          = arm && (r_state == S_IDLE || r_state == S_DONE);
  assign w_commit          = r_avm_write && !avm_waitrequest;
  // Every valid sample seen in CAPTURE counts toward record_len, dropped or not.
  assign w_take            = (r_state == S_CAPTURE) && sample_valid && (r_seen != r_len);
  assign w_push            = w_take && ((r_count != c_FULL) || w_commit);
  assign w_drop            = w_take && !w_push;
  assign w_rptr_next       = r_rptr + c_PTR_W'(w_commit);
  assign w_count_after_pop = r_count - (c_PTR_W+1)'(w_commit);
  // Head is taken from stored entries only, so a fresh push shows up one cycle later.
  assign w_wr_next         = (w_state_next == S_CAPTURE || w_state_next == S_DRAIN) &&
                             (w_count_after_pop != '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_arm_ok) w_state_next = (record_len == '0) ? S_DONE : S_CAPTURE;
      S_CAPTURE:      if (r_seen == r_len) w_state_next = S_DRAIN;
      S_DRAIN:        if (r_count == '0) w_state_next = S_DONE;
      default:        w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge M100CLK or negedge lock) begin
    if (!lock) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge M100CLK) begin
    if (w_push) r_mem[r_wptr] <= sample_in;
  end

  always_ff @(posedge M100CLK or negedge lock) begin
    if (!lock) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_len           <= '0;
      r_seen          <= '0;
      r_avm_address   <= '0;
      r_avm_writedata <= '0;
      r_avm_write     <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_overflow      <= 1'b0;
      r_wr_count      <= '0;
    end else begin
      r_busy <= (w_state_next == S_CAPTURE) || (w_state_next == S_DRAIN);
      r_done <= (w_state_next == S_DONE);
      if (w_arm_ok) begin
        r_wptr        <= '0;
        r_rptr        <= '0;
        r_count       <= '0;
        r_len         <= record_len;
        r_seen        <= '0;
        r_avm_address <= '0;
        r_avm_write   <= 1'b0;
        r_overflow    <= 1'b0;
        r_wr_count    <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
        r_rptr      <= w_rptr_next;
        r_count     <= w_count_after_pop + (c_PTR_W+1)'(w_push);
        r_seen      <= r_seen + ADDR_W'(w_take);
        r_overflow  <= r_overflow | w_drop;
        r_avm_write <= w_wr_next;
        if (w_wr_next) r_avm_writedata <= r_mem[w_rptr_next];
        if (w_commit) begin
          r_avm_address <= r_avm_address + ADDR_W'(1);
          r_wr_count    <= r_wr_count + ADDR_W'(1);
        end
      end
    end
  end

  assign avm_address    = r_avm_address;
  assign avm_writedata  = r_avm_writedata;
  assign avm_write      = r_avm_write;
  assign avm_chipselect = r_avm_write;
  assign avm_byteenable = {2{r_avm_write}};
  assign busy           = r_busy;
  assign done           = r_done;
  assign overflow       = r_overflow;
  assign wr_count       = r_wr_count;

endmodule
`default_nettype wire
